// File: rtl/orient_pkg.sv
// orient_pkg: shared constants, colour codes, receiver states and the field-legality check for orientation_rx.
package orient_pkg;
  localparam int NBITS = 32;
  localparam int FIELD_W = 3;
  localparam int NFIELDS = 9;
  localparam int SYNC_STAGES = 2;
  localparam logic [FIELD_W-1:0] MAX_CODE = 3'd5;
  typedef enum logic [FIELD_W-1:0] {RED, ORANGE, YELLOW, GREEN, BLUE, PURPLE} colour_t;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, PEND} rx_state_t;
  function automatic logic code_ok(input logic [NBITS-1:0] w);
    code_ok = w[NBITS-1:NFIELDS*FIELD_W] == '0;
    for (int k = 0; k < NFIELDS; k++)
      if (w[k*FIELD_W +: FIELD_W] > MAX_CODE) code_ok = 1'b0;
  endfunction
endpackage

// File: rtl/orientation_rx_if.sv
// orientation_rx_if: SPI pins, renderer handshake and status pulses of the orientation receiver.
interface orientation_rx_if;
  import orient_pkg::*;
  logic sck, sdi, load, frame_busy, sdo;
  logic [NBITS-1:0] orientation;
  logic frame_start, err_len, err_code, overrun;
  modport master(output sck, sdi, load, frame_busy,
                 input sdo, orientation, frame_start, err_len, err_code, overrun);
  modport slave(input sck, sdi, load, frame_busy,
                output sdo, orientation, frame_start, err_len, err_code, overrun);
endinterface

// File: rtl/orientation_rx_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchronizer with registered rise/fall strobes aligned to the level output.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] s_q, s_d;
  logic rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    s_d = (s_q << 1) | SYNC_STAGES'(din);
    rise_d = s_d[SYNC_STAGES-1] & ~s_q[SYNC_STAGES-1];
    fall_d = ~s_d[SYNC_STAGES-1] & s_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_q <= s_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level = s_q[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/orientation_rx.sv
// orientation_rx: oversampled SPI receiver that validates and commits the cube orientation word.
// Define ORIENT_CODE_CHECK_EN to reject words with colour codes > 5 or nonzero bits [31:27].
module orientation_rx
  import orient_pkg::*;
(
  input logic clk,
  input logic reset,
  orientation_rx_if.slave bus
);
  localparam logic [5:0] CNT_MAX = 6'(NBITS + 1);
  rx_state_t state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d, tx_q, tx_d, orient_q, orient_d;
  logic [5:0] cnt_q, cnt_d;
  logic frame_start_q, frame_start_d, err_len_q, err_len_d;
  logic err_code_q, err_code_d, overrun_q, overrun_d;
  logic sck_rise, sck_fall, sdi_s, load_s, load_fall, bad_code;
  logic sck_lvl_unused, sdi_rise_unused, sdi_fall_unused, load_rise_unused;
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .reset(reset), .din(bus.sck),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk(clk), .reset(reset), .din(bus.sdi),
    .level(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
    .clk(clk), .reset(reset), .din(bus.load),
    .level(load_s), .rise(load_rise_unused), .fall(load_fall)
  );
`ifdef ORIENT_CODE_CHECK_EN
  always_comb bad_code = !code_ok(shreg_q);
`else
  always_comb bad_code = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    tx_d = tx_q;
    orient_d = orient_q;
    frame_start_d = 1'b0;
    err_len_d = 1'b0;
    err_code_d = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        shreg_d = '0;
        cnt_d = '0;
        tx_d = orient_q;
        if (load_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (sck_rise) begin
          shreg_d = {shreg_q[NBITS-2:0], sdi_s};
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
        end
        if (sck_fall) tx_d = tx_q << 1;
        if (load_fall) state_d = CHECK;
      end
      CHECK: begin
        if (cnt_q != 6'(NBITS)) begin
          err_len_d = 1'b1;
          state_d = IDLE;
        end else if (bad_code) begin
          err_code_d = 1'b1;
          state_d = IDLE;
        end else if (!bus.frame_busy) begin
          orient_d = shreg_q;
          frame_start_d = 1'b1;
          state_d = IDLE;
        end else state_d = PEND;
      end
      PEND: begin
        // a new transfer supersedes the held word even if the renderer frees up in the same cycle
        if (load_s) begin
          overrun_d = 1'b1;
          shreg_d = '0;
          cnt_d = '0;
          tx_d = orient_q;
          state_d = SHIFT;
        end else if (!bus.frame_busy) begin
          orient_d = shreg_q;
          frame_start_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
      tx_q <= '0;
      orient_q <= '0;
      frame_start_q <= 1'b0;
      err_len_q <= 1'b0;
      err_code_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      orient_q <= orient_d;
      frame_start_q <= frame_start_d;
      err_len_q <= err_len_d;
      err_code_q <= err_code_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.sdo = (state_q == SHIFT) & tx_q[NBITS-1];
  assign bus.orientation = orient_q;
  assign bus.frame_start = frame_start_q;
  assign bus.err_len = err_len_q;
  assign bus.err_code = err_code_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_orientation_rx.sv
// tb_orientation_rx: drives SPI transfers and checks commits, errors, readback and timing against a word-level model.
module tb_orientation_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  orientation_rx_if bus();
  orientation_rx dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef ORIENT_CODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  int errors = 0, checks = 0;
  int cyc = 0, fs_n = 0, el_n = 0, ec_n = 0, ov_n = 0, fs_cyc = 0;
  logic [31:0] exp_orient = '0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.frame_start) begin
      fs_n++;
      fs_cyc = cyc;
    end
    if (bus.err_len) el_n++;
    if (bus.err_code) ec_n++;
    if (bus.overrun) ov_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [31:0] w);
    for (int k = 0; k < 9; k++)
      if (((w >> (3 * k)) % 8) > 5) return 1'b0;
    return (w >> 27) == 0;
  endfunction
  task automatic half();
    repeat (6) @(negedge clk);
  endtask
  task automatic xfer(input logic [31:0] w, input int n, output logic [31:0] rd);
    logic [63:0] wx;
    wx = {32'b0, w};
    rd = '0;
    @(negedge clk) bus.load = 1'b1;
    half();
    for (int i = n - 1; i >= 0; i--) begin
      bus.sdi = wx[i];
      half();
      bus.sck = 1'b1;
      rd = {rd[30:0], bus.sdo};
      half();
      bus.sck = 1'b0;
    end
    half();
  endtask
  task automatic drop_load(output int t0);
    @(negedge clk) bus.load = 1'b0;
    t0 = cyc;
  endtask
  task automatic run_txn(input logic [31:0] w, input int n);
    int f0, e0, c0, o0, t0;
    logic [31:0] rd;
    bit el, ec, cm;
    el = n != 32;
    ec = !el && CHK && !legal(w);
    cm = !el && !ec;
    f0 = fs_n; e0 = el_n; c0 = ec_n; o0 = ov_n;
    xfer(w, n, rd);
    drop_load(t0);
    repeat (12) @(negedge clk);
    if (n == 32) check("readback", rd, exp_orient);
    check("frame_start_cnt", fs_n - f0, 32'(cm));
    check("err_len_cnt", el_n - e0, 32'(el));
    check("err_code_cnt", ec_n - c0, 32'(ec));
    check("overrun_cnt", ov_n - o0, 0);
    if (cm) begin
      check("latency", fs_cyc - t0, 4);
      exp_orient = w;
    end
    check("orientation", bus.orientation, exp_orient);
  endtask
  initial begin
    int f0, o0, t0;
    logic [31:0] rd, w;
    int n;
    bus.sck = 1'b0; bus.sdi = 1'b0; bus.load = 1'b0; bus.frame_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_orientation", bus.orientation, 0);
    check("rst_frame_start", 32'(bus.frame_start), 0);
    check("rst_err_len", 32'(bus.err_len), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_sdo", 32'(bus.sdo), 0);
    @(negedge clk) reset = 1'b0;
    run_txn(32'h000A_C688, 32);
    run_txn(32'h0123_ABCD, 31);
    run_txn(32'h0000_6000, 32);
    run_txn(32'h0123_4567, 32);
    run_txn(32'h000A_C688, 32);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        w = '0;
        for (int k = 0; k < 9; k++) w |= 32'($urandom_range(5, 0)) << (3 * k);
      end
      n = ($urandom_range(4, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 31 : 33) : 32;
      run_txn(w, n);
    end
    @(negedge clk) bus.frame_busy = 1'b1;
    f0 = fs_n;
    xfer(32'h0000_0A53, 32, rd);
    drop_load(t0);
    repeat (100) @(negedge clk);
    check("busy_hold_fs", fs_n - f0, 0);
    check("busy_hold_orient", bus.orientation, exp_orient);
    bus.frame_busy = 1'b0;
    t0 = cyc;
    repeat (3) @(negedge clk);
    check("busy_release_fs", fs_n - f0, 1);
    check("busy_release_lat", fs_cyc - t0, 1);
    exp_orient = 32'h0000_0A53;
    check("busy_release_orient", bus.orientation, exp_orient);
    @(negedge clk) bus.frame_busy = 1'b1;
    f0 = fs_n; o0 = ov_n;
    xfer(32'h0000_0024, 32, rd);
    drop_load(t0);
    repeat (10) @(negedge clk);
    xfer(32'h0000_0001, 32, rd);
    check("overrun_readback", rd, exp_orient);
    drop_load(t0);
    repeat (10) @(negedge clk);
    check("overrun_pulse", ov_n - o0, 1);
    check("overrun_no_fs", fs_n - f0, 0);
    bus.frame_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_commit_fs", fs_n - f0, 1);
    exp_orient = 32'h0000_0001;
    check("overrun_commit_orient", bus.orientation, exp_orient);
    run_txn(32'h0000_0A53, 32);
    @(negedge clk) bus.load = 1'b1;
    half();
    for (int i = 0; i < 5; i++) begin
      bus.sdi = 1'b1;
      half();
      bus.sck = 1'b1;
      half();
      bus.sck = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_orientation", bus.orientation, 0);
    check("midrst_frame_start", 32'(bus.frame_start), 0);
    check("midrst_err_len", 32'(bus.err_len), 0);
    check("midrst_err_code", 32'(bus.err_code), 0);
    check("midrst_overrun", 32'(bus.overrun), 0);
    check("midrst_sdo", 32'(bus.sdo), 0);
    bus.load = 1'b0;
    bus.sdi = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    exp_orient = '0;
    run_txn(32'h000A_C688, 32);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
